// File: rtl/field_write_arbiter_if.sv
// Bus bundle between three field writers and the shared TMR register.
// The master side drives requests, field descriptors and fault injection;
// the slave side returns grant/ack, the voted register value and the scrub flag.
interface field_write_arbiter_if;
  logic [2:0]      req;
  logic [2:0][2:0] off;
  logic [2:0][1:0] len;
  logic [2:0][3:0] wdat;
  logic [1:0]      seu_inj;
  logic [2:0]      seu_bit;
  logic [2:0]      gnt;
  logic            ack;
  logic [7:0]      reg_q;
  logic            err;

  modport master (
    output req, off, len, wdat, seu_inj, seu_bit,
    input  gnt, ack, reg_q, err
  );

  modport slave (
    input  req, off, len, wdat, seu_inj, seu_bit,
    output gnt, ack, reg_q, err
  );
endinterface

// File: rtl/field_write_arbiter.sv
// Round-robin arbiter for three requesters writing bit fields into one
// triple-redundant 8-bit register. A granted write is committed DEL cycles
// after the grant as a read-modify-write of the voted value into all copies.
// Single-copy upsets can be injected; an idle scrub repairs divergent copies.
module field_write_arbiter #(
  parameter int unsigned DEL = 2
) (
  input logic            clk,
  input logic            rstn,
  field_write_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [2:0] gnt_q, gnt_d;
  logic       ack_q, ack_d;
  logic       err_q;

  logic [7:0] c0, c1, c2;
  logic [7:0] maj;
  logic [7:0] merged;

  logic [2:0] off_l;
  logic [1:0] len_l;
  logic [3:0] wdat_l;

  logic [1:0] win;
  logic       grant;
  logic       commit;
  logic       scrub;
  logic       copies_eq;

  // Bitwise 2-of-3 vote.
  function automatic logic [7:0] vote3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Replace bits [off +: len+1] of base with dat; bits beyond 7 are dropped.
  function automatic logic [7:0] merge_field(input logic [7:0] base, input logic [2:0] off,
                                             input logic [1:0] len, input logic [3:0] dat);
    logic [7:0] r;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] idx;
    r   = base;
    lo  = {1'b0, off};
    hi  = {1'b0, off} + {2'b00, len};
    idx = 4'd0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) >= lo && 4'(b) <= hi) begin
        idx  = 4'(b) - lo;
        r[b] = dat[idx[1:0]];
      end
    end
    return r;
  endfunction

  assign maj       = vote3(c0, c1, c2);
  assign merged    = merge_field(maj, off_l, len_l, wdat_l);
  assign copies_eq = (c0 == c1) && (c1 == c2);
  assign scrub     = (state_q == IDLE) && (bus.req == 3'b000) &&
                     (bus.seu_inj == 2'd0) && !copies_eq;

  // Round-robin winner: search starts one past the last granted requester.
  always_comb begin
    logic [1:0] p0, p1, p2;
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_q)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (bus.req[p0])      win = p0;
    else if (bus.req[p1]) win = p1;
    else                  win = p2;
  end

  // Next-state and pulse outputs for the grant/commit sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = 3'b000;
    ack_d   = 1'b0;
    grant   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 3'b000) begin
          grant   = 1'b1;
          state_d = WAIT;
          cnt_d   = 3'(DEL);
          last_d  = win;
          gnt_d   = 3'b001 << win;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 2'd2;
      gnt_q   <= 3'b000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= scrub;
    end
  end

  // Winner's field descriptor, held for the commit; no reset needed.
  always_ff @(posedge clk) begin
    if (grant) begin
      off_l  <= bus.off[win];
      len_l  <= bus.len[win];
      wdat_l <= bus.wdat[win];
    end
  end

  // Redundant copies: commit beats injection, injection beats scrub.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c0 <= 8'h00;
      c1 <= 8'h00;
      c2 <= 8'h00;
    end else if (commit) begin
      c0 <= merged;
      c1 <= merged;
      c2 <= merged;
    end else if (bus.seu_inj != 2'd0) begin
      case (bus.seu_inj)
        2'd1:    c0[bus.seu_bit] <= ~c0[bus.seu_bit];
        2'd2:    c1[bus.seu_bit] <= ~c1[bus.seu_bit];
        default: c2[bus.seu_bit] <= ~c2[bus.seu_bit];
      endcase
    end else if (scrub) begin
      c0 <= maj;
      c1 <= maj;
      c2 <= maj;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.reg_q = maj;

endmodule

// File: tb/tb_field_write_arbiter.sv
// Directed and randomized bench for field_write_arbiter with a cycle-level
// reference model of arbitration, delayed commit, injection and scrub.
module tb_field_write_arbiter;
  localparam int DEL = 2;

  logic clk;
  logic rstn;
  field_write_arbiter_if bus ();

  field_write_arbiter #(.DEL(DEL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [7:0] mc [3];
  int         m_last;
  bit         m_busy;
  int         m_commit_at;
  int         cyc;
  int         l_off, l_len;
  logic [3:0] l_wdat;
  logic [2:0] exp_gnt;
  logic       exp_ack, exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_vote();
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      int n;
      n = int'(mc[0][b]) + int'(mc[1][b]) + int'(mc[2][b]);
      v[b] = (n >= 2);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) mc[i] = 8'h00;
    m_last = 2; m_busy = 0; m_commit_at = -1; cyc = 0;
  endtask

  task automatic clear_inputs();
    bus.req = 3'b000; bus.seu_inj = 2'd0; bus.seu_bit = 3'd0;
    for (int i = 0; i < 3; i++) begin
      bus.off[i] = 3'd0; bus.len[i] = 2'd0; bus.wdat[i] = 4'd0;
    end
  endtask

  // One clock edge: predict from current inputs, clock, then compare.
  task automatic step();
    bit committed;
    bit idle_before;
    committed   = 0;
    idle_before = !m_busy;
    exp_gnt = 3'b000; exp_ack = 1'b0; exp_err = 1'b0;
    if (!m_busy) begin
      if (bus.req != 3'b000) begin
        int w;
        bit found;
        w = 0; found = 0;
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (!found && bus.req[c]) begin w = c; found = 1; end
        end
        l_off = int'(bus.off[w]); l_len = int'(bus.len[w]); l_wdat = bus.wdat[w];
        m_last = w; m_busy = 1; m_commit_at = cyc + DEL;
        exp_gnt = 3'(1 << w);
      end
    end else if (cyc == m_commit_at) begin
      logic [7:0] v;
      v = m_vote();
      for (int b = 0; b <= l_len; b++)
        if (l_off + b < 8) v[l_off + b] = l_wdat[b];
      for (int i = 0; i < 3; i++) mc[i] = v;
      exp_ack = 1'b1; m_busy = 0; committed = 1;
    end
    if (!committed && bus.seu_inj != 2'd0) begin
      int si;
      si = int'(bus.seu_inj) - 1;
      mc[si][bus.seu_bit] = ~mc[si][bus.seu_bit];
    end else if (!committed && idle_before && bus.req == 3'b000 && bus.seu_inj == 2'd0 &&
                 !(mc[0] == mc[1] && mc[1] == mc[2])) begin
      logic [7:0] v;
      v = m_vote();
      for (int i = 0; i < 3; i++) mc[i] = v;
      exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt",   32'(bus.gnt),   32'(exp_gnt));
    chk("ack",   32'(bus.ack),   32'(exp_ack));
    chk("err",   32'(bus.err),   32'(exp_err));
    chk("reg_q", 32'(bus.reg_q), 32'(m_vote()));
  endtask

  // Assert reset mid-cycle, check asynchronous clearing, release on a falling edge.
  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    #2;
    chk("rst_gnt",   32'(bus.gnt),   32'h0);
    chk("rst_ack",   32'(bus.ack),   32'h0);
    chk("rst_err",   32'(bus.err),   32'h0);
    chk("rst_reg_q", 32'(bus.reg_q), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [2:0] gseq [4];
    int         gcyc [4];
    int         ng;

    rstn = 1'b1;
    clear_inputs();
    model_reset();
    #3;
    do_reset();

    // Basic field write: off 2, width 2, data 11 -> 0x0C
    bus.req = 3'b001; bus.off[0] = 3'd2; bus.len[0] = 2'd1; bus.wdat[0] = 4'b0011;
    step();
    chk("basic_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 3'b000;
    step();
    chk("basic_noack_early", 32'(bus.ack), 32'h0);
    step();
    chk("basic_ack",   32'(bus.ack),   32'h1);
    chk("basic_reg_q", 32'(bus.reg_q), 32'h0C);
    step();

    // Field crossing bit 7 is truncated, low bits untouched
    do_reset();
    bus.req = 3'b001; bus.off[0] = 3'd6; bus.len[0] = 2'd3; bus.wdat[0] = 4'b1111;
    step();
    bus.req = 3'b000;
    repeat (DEL) step();
    chk("trunc_reg_q", 32'(bus.reg_q), 32'hC0);
    step();

    // All requesters held: rotation 001,010,100,001 at DEL+1 spacing
    do_reset();
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.off[i] = 3'(i * 2); bus.len[i] = 2'd1; bus.wdat[i] = 4'(i + 1);
    end
    ng = 0;
    for (int s = 0; s < 4 * (DEL + 1); s++) begin
      step();
      if (bus.gnt != 3'b000 && ng < 4) begin
        gseq[ng] = bus.gnt; gcyc[ng] = cyc; ng++;
      end
    end
    chk("rr_count", 32'(ng), 32'd4);
    chk("rr_g0", 32'(gseq[0]), 32'b001);
    chk("rr_g1", 32'(gseq[1]), 32'b010);
    chk("rr_g2", 32'(gseq[2]), 32'b100);
    chk("rr_g3", 32'(gseq[3]), 32'b001);
    chk("rr_space", 32'(gcyc[3] - gcyc[2]), 32'(DEL + 1));
    bus.req = 3'b000;
    repeat (DEL + 1) step();

    // Injection into copy 1 is masked by the vote, then scrubbed once
    do_reset();
    bus.seu_inj = 2'd2; bus.seu_bit = 3'd5;
    step();
    chk("seu_reg_q", 32'(bus.reg_q), 32'h00);
    chk("seu_c1", 32'(dut.c1), 32'h20);
    bus.seu_inj = 2'd0;
    step();
    chk("scrub_err", 32'(bus.err), 32'h1);
    step();
    chk("scrub_err_once", 32'(bus.err), 32'h0);
    chk("scrub_c0", 32'(dut.c0), 32'h00);
    chk("scrub_c1", 32'(dut.c1), 32'h00);
    chk("scrub_c2", 32'(dut.c2), 32'h00);

    // Injection on the commit edge is ignored
    do_reset();
    bus.req = 3'b001; bus.off[0] = 3'd0; bus.len[0] = 2'd0; bus.wdat[0] = 4'd1;
    step();
    bus.req = 3'b000;
    repeat (DEL - 1) step();
    bus.seu_inj = 2'd1; bus.seu_bit = 3'd3;
    step();
    chk("cinj_ack", 32'(bus.ack), 32'h1);
    bus.seu_inj = 2'd0;
    step();
    chk("cinj_noerr", 32'(bus.err), 32'h0);
    chk("cinj_c0", 32'(dut.c0), 32'h01);
    step();

    // Reset during WAIT abandons the write
    do_reset();
    bus.req = 3'b010; bus.off[1] = 3'd0; bus.len[1] = 2'd3; bus.wdat[1] = 4'hF;
    step();
    chk("abort_gnt", 32'(bus.gnt), 32'b010);
    bus.req = 3'b000;
    step();
    do_reset();
    repeat (DEL + 2) step();
    chk("abort_reg_q", 32'(bus.reg_q), 32'h00);

    // Randomized traffic with occasional upsets
    do_reset();
    for (int s = 0; s < 600; s++) begin
      bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.req = 3'b000;
      for (int i = 0; i < 3; i++) begin
        bus.off[i]  = 3'($urandom_range(0, 7));
        bus.len[i]  = 2'($urandom_range(0, 3));
        bus.wdat[i] = 4'($urandom_range(0, 15));
      end
      bus.seu_inj = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.seu_bit = 3'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/field_write_arbiter.md
FIELD_WRITE_ARBITER -- requirements
Module: field_write_arbiter

Interface
REQ-001 SHALL have parameter DEL, default 2, meaning the commit delay in cycles from grant to write, legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req  input  3  per-requester write request, level, held until gnt.
REQ-005 SHALL have port off  input  3x3 (off0..off2)  per-requester field base bit, 0..7.
REQ-006 SHALL have port len  input  3x2 (len0..len2)  per-requester field width minus 1 (width 1..4).
REQ-007 SHALL have port wdat  input  3x4 (wdat0..wdat2)  per-requester field data, LSB-aligned.
REQ-008 SHALL have port seu_inj  input  2  fault injection: 1/2/3 selects copy 0/1/2, 0 = none.
REQ-009 SHALL have port seu_bit  input  3  bit index flipped by injection.
REQ-010 SHALL have port gnt  output  3  one-hot grant, one-cycle pulse.
REQ-011 SHALL have port ack  output  1  one-cycle pulse, commit done.
REQ-012 SHALL have port reg_q  output  8  bitwise 2-of-3 majority of the three internal copies.
REQ-013 SHALL have port err  output  1  one-cycle pulse, scrub corrected a mismatch.

Function
REQ-014 SHALL store the shared register as three 8-bit copies c0, c1, c2; reg_q is combinational majority.
REQ-015 SHALL implement FSM states IDLE and WAIT with down-counter cnt (3 bits).
REQ-016 SHALL, in IDLE at an edge with any req bit high, pick a winner round-robin starting at last+1 mod 3, latch its off/len/wdat, set last=winner, drive gnt[winner]=1 for the following cycle, load cnt=DEL, and go to WAIT.
REQ-017 SHALL, in WAIT, decrement cnt each edge; at the edge where cnt==1, commit, pulse ack for the following cycle, and return to IDLE.
REQ-018 SHALL commit as: new value = reg_q with bits [off +: len+1] replaced by wdat[len:0], written identically to c0, c1 and c2.
REQ-019 SHALL drop field bits whose index exceeds 7 (no wrap-around to bit 0).
REQ-020 SHALL ignore req in WAIT; a requester keeps req high and is served on a later arbitration.
REQ-021 SHALL give, for sampling edge E0, gnt during E0..E1, commit at edge E0+DEL, ack during E0+DEL..E0+DEL+1, next arbitration edge no earlier than E0+DEL+1.
REQ-022 SHALL, at any edge not a commit edge, flip bit seu_bit of the copy selected by seu_inj when seu_inj!=0.
REQ-023 SHALL ignore seu_inj on a commit edge.
REQ-024 SHALL, in IDLE with req==0, seu_inj==0 and copies unequal, rewrite all copies with reg_q and pulse err for the following cycle (scrub).
REQ-025 SHALL give injection priority over scrub on the same edge; scrub occurs at the next qualifying edge.
REQ-026 SHALL not scrub in WAIT; commit restores all copies.

Reset
REQ-027 SHALL, while rstn low, asynchronously force c0=c1=c2=0, reg_q=0, gnt=0, ack=0, err=0, state IDLE, cnt=0, last=2 (requester 0 wins first).
REQ-028 SHALL, on reset mid-WAIT, abandon the pending write; no ack is produced.

Verification
REQ-029 SHALL cover: DEL=2, req=001, off0=2, len0=1, wdat0=0011 at E0 -> gnt=001 in E0..E1, reg_q=0x0C after E2, ack in E2..E3.
REQ-030 SHALL cover: req=111 held continuously from reset -> grants in order 001,010,100,001, one every DEL+1 cycles.
REQ-031 SHALL cover: off=6, len=3, wdat=1111 from reg_q=0x00 -> reg_q=0xC0, bits 0/1 unchanged.
REQ-032 SHALL cover: seu_inj=2, seu_bit=5 in IDLE with reg_q=0x00 -> reg_q stays 0x00; next idle edge scrubs; err pulses once; copies all 0x00.
REQ-033 SHALL cover: seu_inj=1 on a commit edge -> injection ignored; no err follows.
REQ-034 SHALL cover: rstn low one cycle after grant -> gnt, ack and reg_q all 0; no commit after rstn release.
